ft601_bus_emu: RTL and testbench
================================

// Module: ft601_bus_emu
// PURPOSE
//  Device-side (chip-side) emulator of the FT601 245-sync FIFO bus, the responder to our FPGA bus-master FSM.
//  Drives txe_n/rxf_n, sinks WR# writes into an upload FIFO toward a host model, and sources host commands
//  (START 32'h11111111 / STOP 32'h00000000) onto the bus under OE#/RD#. Used in system sims and in loopback builds without the chip.
// PARAMETERS
//  DATA_LEN  32  bus data width
//  BE_LEN    4   byte-enable width
//  TX_DEPTH  16  upload FIFO depth (FPGA->host), power of 2
//  RX_DEPTH  4   command FIFO depth (host->FPGA), power of 2
// PORTS
//  clk          in   1                      bus clock; this block acts on posedge (master acts on negedge)
//  rst_n        in   1                      reset, asynchronous, active-low
//  wr_n         in   1                      WR# from master
//  rd_n         in   1                      RD# from master
//  oe_n         in   1                      OE# from master
//  drive_tx     in   1                      master owns bus
//  data_i       in   DATA_LEN               bus data from master
//  be_i         in   BE_LEN                 byte enables from master
//  data_o       out  DATA_LEN               bus data to master
//  be_o         out  BE_LEN                 byte enables to master
//  data_oe      out  1                      emulator drives bus (= !oe_n)
//  txe_n        out  1                      0 = upload FIFO has space
//  rxf_n        out  1                      0 = command FIFO has data
//  cmd_valid    in   1                      host pushes command word
//  cmd_data     in   DATA_LEN               host command word
//  cmd_ready    out  1                      command FIFO not full
//  up_valid     out  1                      upload word available
//  up_data      out  DATA_LEN               upload head data
//  up_be        out  BE_LEN                 upload head byte enables
//  up_ready     in   1                      host pops upload word
//  tx_count     out  $clog2(TX_DEPTH)+1     upload occupancy
//  rx_count     out  $clog2(RX_DEPTH)+1     command occupancy
//  err_flags    out  4                      sticky: [0] wr when full, [1] rd when empty, [2] rd_n low with oe_n high, [3] bus conflict
// BEHAVIOUR
//  Reset (async): both FIFOs flushed; txe_n=1, rxf_n=1, cmd_ready=0, up_valid=0, counts=0, err_flags=0,
//   data_o=0, be_o=0, hold_vld=0. Reset mid-transfer aborts it; no partial word survives.
//  Upload path, per posedge: wr_n==0 -> push {be_i,data_i}; if full, drop and set err[0]. up_valid&&up_ready -> pop.
//   Simultaneous push+pop: both happen, count unchanged, including when full (the pop frees the slot first).
//   up_valid = !empty; up_data/up_be show head combinationally.
//  Command path: cmd_ready registered = !full after update; push on cmd_valid&&cmd_ready.
//   Pop on posedge with rd_n==0 && oe_n==0; if empty, no pop and set err[1]. rd_n==0 && oe_n==1 -> set err[2], no pop.
//   Simultaneous host push and bus pop: both happen.
//  Read data presentation: data_oe = !oe_n (combinational). be_o = all ones while data_oe, else 0.
//   On pop, hold_reg <= popped word and hold_vld <= 1, so the master's capture edge (negedge after the RD# posedge) sees the popped word.
//   data_o = hold_vld ? hold_reg : head. hold_vld clears on the posedge where oe_n==1.
//  Flags: txe_n, rxf_n registered on posedge from post-update state: txe_n = (TX free == 0); rxf_n = RX empty.
//   Flags see a push/pop one posedge later. A master that samples txe_n then writes within 3 edges may overrun by one word;
//   err[0] reports this.
//  Bus conflict: any posedge with drive_tx==1 && oe_n==0 sets err[3]. The write is still accepted if wr_n==0.
//  err_flags are cleared only by rst_n.
//  Arithmetic: pointers are log2(DEPTH) bits with natural wrap. Counts are one bit wider and saturate neither way:
//   guards prevent over- and underflow.
// TESTING
//  1. Reset, then host pushes 32'h11111111 -> rxf_n=0 after 1 posedge. Master OE/RD/CAP -> master captures 32'h11111111,
//     rxf_n=1, rx_count=0, err_flags=0.
//  2. After START, preload 5 known words into the master-side FIFO -> up_valid shows 5 words in order with up_be=4'hF;
//     tx_count peaks <=5, txe_n stays 0.
//  3. up_ready=0, master keeps writing -> tx_count reaches 16, txe_n=1; no word lost or reordered. Any 17th WR# sets err[0] and is dropped.
//  4. At full, same posedge pop (up_ready=1) and write -> count stays 16, err[0] stays 0, order preserved.
//  5. Force rd_n=0 with oe_n=0 on empty command FIFO -> err[1]=1. Force rd_n=0 with oe_n=1 -> err[2]=1.
//     Force drive_tx=1 with oe_n=0 -> err[3]=1.
//  6. Assert rst_n low mid-write burst (tx_count=7) -> immediately tx_count=0, txe_n=1, up_valid=0, err_flags=0;
//     normal operation resumes after release.

Source files
------------

// File: rtl/ft601_bus_emu.sv
// Chip-side emulator of the FT601 245-sync FIFO bus: sinks master writes into an upload FIFO
// for a host model and sources host command words back onto the bus under OE#/RD#.
module ft601_bus_emu #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned BE_LEN   = 4,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // Bus side
  input  logic                          wr_n,
  input  logic                          rd_n,
  input  logic                          oe_n,
  input  logic                          drive_tx,
  input  logic [DATA_LEN-1:0]           data_i,
  input  logic [BE_LEN-1:0]             be_i,
  output logic [DATA_LEN-1:0]           data_o,
  output logic [BE_LEN-1:0]             be_o,
  output logic                          data_oe,
  output logic                          txe_n,
  output logic                          rxf_n,
  // Host side
  input  logic                          cmd_valid,
  input  logic [DATA_LEN-1:0]           cmd_data,
  output logic                          cmd_ready,
  output logic                          up_valid,
  output logic [DATA_LEN-1:0]           up_data,
  output logic [BE_LEN-1:0]             up_be,
  input  logic                          up_ready,
  // Status
  output logic [$clog2(TX_DEPTH):0]     tx_count,
  output logic [$clog2(RX_DEPTH):0]     rx_count,
  output logic [3:0]                    err_flags
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned TxCw = TxAw + 1;
  localparam int unsigned RxCw = RxAw + 1;
  localparam int unsigned TxW  = DATA_LEN + BE_LEN;

  // Upload FIFO state
  logic [TxW-1:0]      tx_mem_q [TX_DEPTH];
  logic [TxAw-1:0]     tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TxAw-1:0]     tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TxCw-1:0]     tx_cnt_q, tx_cnt_d;
  logic                tx_full, tx_empty, tx_push, tx_pop, tx_req;

  // Command FIFO state
  logic [DATA_LEN-1:0] rx_mem_q [RX_DEPTH];
  logic [RxAw-1:0]     rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RxAw-1:0]     rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RxCw-1:0]     rx_cnt_q, rx_cnt_d;
  logic                rx_empty, rx_push, rx_pop, rx_req;
  logic [DATA_LEN-1:0] rx_head;

  // Read-data hold and registered flags
  logic [DATA_LEN-1:0] hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                txe_n_q, txe_n_d;
  logic                rxf_n_q, rxf_n_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [3:0]          err_q, err_d;

  // Upload path decode
  always_comb begin
    tx_full  = (tx_cnt_q == TxCw'(TX_DEPTH));
    tx_empty = (tx_cnt_q == '0);
    tx_req   = ~wr_n;
    tx_pop   = ~tx_empty & up_ready;
    // A same-edge pop frees the slot, so a write at full is still accepted.
    tx_push  = tx_req & (~tx_full | tx_pop);
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + TxCw'(tx_push) - TxCw'(tx_pop);
    txe_n_d     = (tx_cnt_d == TxCw'(TX_DEPTH));
  end

  // Command path decode
  always_comb begin
    rx_empty = (rx_cnt_q == '0);
    rx_head  = rx_mem_q[rx_rd_ptr_q];
    rx_push  = cmd_valid & cmd_ready_q;
    rx_req   = ~rd_n & ~oe_n;
    rx_pop   = rx_req & ~rx_empty;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + RxCw'(rx_push) - RxCw'(rx_pop);
    rxf_n_d     = (rx_cnt_d == '0);
    cmd_ready_d = (rx_cnt_d != RxCw'(RX_DEPTH));
  end

  // Hold register keeps the popped word visible for the master's negedge capture.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (rx_pop) begin
      hold_d     = rx_head;
      hold_vld_d = 1'b1;
    end else if (oe_n) begin
      hold_vld_d = 1'b0;
    end
  end

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (tx_req & ~tx_push);
    err_d[1] = err_q[1] | (rx_req & rx_empty);
    err_d[2] = err_q[2] | (~rd_n & oe_n);
    err_d[3] = err_q[3] | (drive_tx & ~oe_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      txe_n_q     <= 1'b1;
      rxf_n_q     <= 1'b1;
      cmd_ready_q <= 1'b0;
      err_q       <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      txe_n_q     <= txe_n_d;
      rxf_n_q     <= rxf_n_d;
      cmd_ready_q <= cmd_ready_d;
      err_q       <= err_d;
    end
  end

  // Storage is cleared on reset so that no stale word reaches either output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TX_DEPTH); i++) tx_mem_q[i] <= '0;
    end else if (tx_push) begin
      tx_mem_q[tx_wr_ptr_q] <= {be_i, data_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RX_DEPTH); i++) rx_mem_q[i] <= '0;
    end else if (rx_push) begin
      rx_mem_q[rx_wr_ptr_q] <= cmd_data;
    end
  end

  always_comb begin
    data_oe   = ~oe_n;
    be_o      = {BE_LEN{data_oe}};
    data_o    = hold_vld_q ? hold_q : rx_head;
    txe_n     = txe_n_q;
    rxf_n     = rxf_n_q;
    cmd_ready = cmd_ready_q;
    up_valid  = ~tx_empty;
    {up_be, up_data} = tx_mem_q[tx_rd_ptr_q];
    tx_count  = tx_cnt_q;
    rx_count  = rx_cnt_q;
    err_flags = err_q;
  end

endmodule

// File: tb/tb_ft601_bus_emu.sv
// Directed bench for ft601_bus_emu: the bench plays the negedge master and the host model.
module tb_ft601_bus_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_n, rd_n, oe_n, drive_tx;
  logic [31:0] data_i;
  logic [3:0]  be_i;
  logic [31:0] data_o;
  logic [3:0]  be_o;
  logic        data_oe, txe_n, rxf_n;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_ready;
  logic        up_valid;
  logic [31:0] up_data;
  logic [3:0]  up_be;
  logic        up_ready;
  logic [4:0]  tx_count;
  logic [2:0]  rx_count;
  logic [3:0]  err_flags;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ft601_bus_emu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_n      (wr_n),
    .rd_n      (rd_n),
    .oe_n      (oe_n),
    .drive_tx  (drive_tx),
    .data_i    (data_i),
    .be_i      (be_i),
    .data_o    (data_o),
    .be_o      (be_o),
    .data_oe   (data_oe),
    .txe_n     (txe_n),
    .rxf_n     (rxf_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_be     (up_be),
    .up_ready  (up_ready),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .err_flags (err_flags)
  );

  task automatic idle_inputs();
    wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; drive_tx = 1'b0;
    data_i = '0; be_i = '0; cmd_valid = 1'b0; cmd_data = '0; up_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if ({txe_n, rxf_n, cmd_ready, up_valid} !== 4'b1100)
      $display("FAIL reset_flags: got %b want 1100", {txe_n, rxf_n, cmd_ready, up_valid});
    else passes++;
    checks++;
    if ({tx_count, rx_count, err_flags} !== 12'h000)
      $display("FAIL reset_counts: got %h want 000", {tx_count, rx_count, err_flags});
    else passes++;
    checks++;
    if ({data_o, be_o, data_oe} !== 37'h0)
      $display("FAIL reset_bus: got %h want 0", {data_o, be_o, data_oe});
    else passes++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({txe_n, rxf_n, cmd_ready} !== 3'b011)
      $display("FAIL post_reset_flags: got %b want 011", {txe_n, rxf_n, cmd_ready});
    else passes++;
  endtask

  task automatic test_command_read();
    @(negedge clk) begin cmd_valid = 1'b1; cmd_data = 32'h1111_1111; end
    @(posedge clk); #1;
    checks++;
    if ({rxf_n, rx_count} !== 4'b0001)
      $display("FAIL cmd_push: got rxf_n=%b cnt=%0d want 0/1", rxf_n, rx_count);
    else passes++;
    @(negedge clk) begin cmd_valid = 1'b0; oe_n = 1'b0; end
    #1;
    checks++;
    if ({data_oe, be_o, data_o} !== {1'b1, 4'hF, 32'h1111_1111})
      $display("FAIL oe_head: got %b %h %h want 1 f 11111111", data_oe, be_o, data_o);
    else passes++;
    @(negedge clk) rd_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rxf_n, rx_count} !== 4'b1000)
      $display("FAIL cmd_pop: got rxf_n=%b cnt=%0d want 1/0", rxf_n, rx_count);
    else passes++;
    @(negedge clk);
    checks++;
    if (data_o !== 32'h1111_1111)
      $display("FAIL capture: got %h want 11111111", data_o);
    else passes++;
    rd_n = 1'b1; oe_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({data_oe, be_o, err_flags} !== 9'h0)
      $display("FAIL oe_release: got %b %h err=%b want 0 0 0000", data_oe, be_o, err_flags);
    else passes++;
  endtask

  task automatic test_upload();
    logic [31:0] w [5] = '{32'hCAFE_0001, 32'h1234_5678, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h8000_0001};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) begin wr_n = 1'b0; data_i = w[i]; be_i = 4'hF; end
    end
    @(negedge clk) wr_n = 1'b1;
    checks++;
    if ({txe_n, tx_count} !== {1'b0, 5'd5})
      $display("FAIL upload_count: got txe_n=%b cnt=%0d want 0/5", txe_n, tx_count);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({up_valid, up_be, up_data} !== {1'b1, 4'hF, w[i]})
        $display("FAIL upload_word%0d: got %b %h %h want 1 f %h", i, up_valid, up_be, up_data, w[i]);
      else passes++;
      up_ready = 1'b1;
    end
    @(negedge clk) up_ready = 1'b0;
    checks++;
    if ({up_valid, tx_count} !== 6'd0)
      $display("FAIL upload_empty: got v=%b cnt=%0d want 0/0", up_valid, tx_count);
    else passes++;
  endtask

  task automatic test_fill_overrun();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) begin wr_n = 1'b0; data_i = 32'hA0 + i; be_i = 4'h5; end
    end
    @(negedge clk) wr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({txe_n, tx_count, err_flags[0]} !== {1'b1, 5'd16, 1'b0})
      $display("FAIL fill: got txe_n=%b cnt=%0d err0=%b want 1/16/0", txe_n, tx_count, err_flags[0]);
    else passes++;
    // Push and pop on the same edge while full.
    @(negedge clk) begin wr_n = 1'b0; data_i = 32'hB0; up_ready = 1'b1; end
    @(posedge clk); #1;
    checks++;
    if ({tx_count, err_flags[0], up_data} !== {5'd16, 1'b0, 32'hA1})
      $display("FAIL full_swap: got cnt=%0d err0=%b head=%h want 16/0/a1", tx_count, err_flags[0], up_data);
    else passes++;
    @(negedge clk) begin data_i = 32'hDEAD; up_ready = 1'b0; end
    @(posedge clk); #1;
    checks++;
    if ({tx_count, err_flags[0]} !== {5'd16, 1'b1})
      $display("FAIL overrun: got cnt=%0d err0=%b want 16/1", tx_count, err_flags[0]);
    else passes++;
    @(negedge clk) wr_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'hA1 + i : 32'hB0;
      if (i > 0) @(negedge clk);
      checks++;
      if ({up_be, up_data} !== {4'h5, exp})
        $display("FAIL drain%0d: got %h %h want 5 %h", i, up_be, up_data, exp);
      else passes++;
      up_ready = 1'b1;
    end
    @(negedge clk) up_ready = 1'b0;
    checks++;
    if ({up_valid, tx_count, txe_n} !== 7'd0)
      $display("FAIL drain_end: got v=%b cnt=%0d txe_n=%b want 0/0/0", up_valid, tx_count, txe_n);
    else passes++;
  endtask

  task automatic test_errors();
    @(negedge clk) begin rd_n = 1'b0; oe_n = 1'b0; end
    @(posedge clk); #1;
    checks++;
    if ({err_flags, rx_count} !== {4'b0011, 3'd0})
      $display("FAIL rd_empty: got err=%b cnt=%0d want 0011/0", err_flags, rx_count);
    else passes++;
    @(negedge clk) oe_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (err_flags !== 4'b0111)
      $display("FAIL rd_no_oe: got %b want 0111", err_flags);
    else passes++;
    @(negedge clk) begin
      rd_n = 1'b1; oe_n = 1'b0; drive_tx = 1'b1; wr_n = 1'b0; data_i = 32'h77; be_i = 4'hF;
    end
    @(posedge clk); #1;
    checks++;
    if ({err_flags, tx_count, up_data} !== {4'b1111, 5'd1, 32'h77})
      $display("FAIL conflict: got err=%b cnt=%0d head=%h want 1111/1/77", err_flags, tx_count, up_data);
    else passes++;
    @(negedge clk) idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) begin wr_n = 1'b0; data_i = 32'hC0 + i; be_i = 4'hF; end
    end
    @(posedge clk); #1;
    checks++;
    if (tx_count !== 5'd7)
      $display("FAIL burst_count: got %0d want 7", tx_count);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_count, txe_n, up_valid, err_flags} !== {5'd0, 1'b1, 1'b0, 4'd0})
      $display("FAIL mid_reset: got cnt=%0d txe_n=%b v=%b err=%b want 0/1/0/0000",
               tx_count, txe_n, up_valid, err_flags);
    else passes++;
    @(negedge clk) begin rst_n = 1'b1; wr_n = 1'b1; end
    @(negedge clk) begin wr_n = 1'b0; data_i = 32'h55; end
    @(negedge clk) wr_n = 1'b1;
    checks++;
    if ({tx_count, txe_n, up_valid, up_data} !== {5'd1, 1'b0, 1'b1, 32'h55})
      $display("FAIL resume: got cnt=%0d txe_n=%b v=%b head=%h want 1/0/1/55",
               tx_count, txe_n, up_valid, up_data);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_command_read();
    test_upload();
    test_fill_overrun();
    test_errors();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
